// File: rtl/vga_controller.sv
`default_nettype none
// ============================================================================
// Module      : vga_controller
// Description : 640x480@60 VGA timing generator. Produces a 25 MHz pixel
//               clock from a 50 MHz system clock, pixel/line counters,
//               registered sync/blank strobes and a frame-start pulse.
//               Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync/blank_n
//               by one pixel to line up with a registered image ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_controller #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       vga_clk,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       sync_n,
   output logic       frame_start
);

   localparam logic [9:0] c_H_VIS = 10'(H_VISIBLE);
   localparam logic [9:0] c_H_SS  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_H_SE  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] c_H_MAX = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] c_V_VIS = 10'(V_VISIBLE);
   localparam logic [9:0] c_V_SS  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_V_SE  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] c_V_MAX = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

   logic       r_pix_en;
   logic       r_started;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_blank_n;
   logic       r_frame_start;

   logic [9:0] w_x_nxt;
   logic [9:0] w_y_nxt;
   logic       w_x_end;
   logic       w_y_end;
   logic       w_hsync_nxt;
   logic       w_vsync_nxt;
   logic       w_blank_n_nxt;
   logic       w_frame_nxt;

   assign w_x_end = (r_x == c_H_MAX);
   assign w_y_end = (r_y == c_V_MAX);

   // Next counter values; they only move on pixel-enable cycles, and the
   // x and y wraps resolve together so 799,524 goes straight to 0,0.
   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (r_pix_en) begin
         if (w_x_end) begin
            w_x_nxt = 10'd0;
            w_y_nxt = w_y_end ? 10'd0 : r_y + 10'd1;
         end else begin
            w_x_nxt = r_x + 10'd1;
         end
      end
   end

   // Strobes decoded from the next counter values so the registered
   // outputs switch on the same edge as x/y.
   assign w_hsync_nxt   = ~((w_x_nxt >= c_H_SS) && (w_x_nxt <= c_H_SE));
   assign w_vsync_nxt   = ~((w_y_nxt >= c_V_SS) && (w_y_nxt <= c_V_SE));
   assign w_blank_n_nxt = (w_x_nxt < c_H_VIS) && (w_y_nxt < c_V_VIS);
   // A frame starts on the 0,0 wrap, and also on the first edge after reset
   // because the counters already sit at 0,0 then.
   assign w_frame_nxt   = (r_pix_en && w_x_end && w_y_end) || !r_started;

   // Pixel enable, counters, frame pulse and aligned strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pix_en      <= 1'b0;
         r_started     <= 1'b0;
         r_x           <= 10'd0;
         r_y           <= 10'd0;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_blank_n     <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_en      <= ~r_pix_en;
         r_started     <= 1'b1;
         r_x           <= w_x_nxt;
         r_y           <= w_y_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_blank_n     <= w_blank_n_nxt;
         r_frame_start <= w_frame_nxt;
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   logic [1:0] r_hsync_d;
   logic [1:0] r_vsync_d;
   logic [1:0] r_blank_n_d;

   // Two-clk (one-pixel) delay of the strobes to match ROM read latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hsync_d   <= 2'b11;
         r_vsync_d   <= 2'b11;
         r_blank_n_d <= 2'b00;
      end else begin
         r_hsync_d   <= {r_hsync_d[0], r_hsync};
         r_vsync_d   <= {r_vsync_d[0], r_vsync};
         r_blank_n_d <= {r_blank_n_d[0], r_blank_n};
      end
   end

   assign hsync   = r_hsync_d[1];
   assign vsync   = r_vsync_d[1];
   assign blank_n = r_blank_n_d[1];
`else
   assign hsync   = r_hsync;
   assign vsync   = r_vsync;
   assign blank_n = r_blank_n;
`endif

   assign vga_clk     = r_pix_en;
   assign x           = r_x;
   assign y           = r_y;
   assign frame_start = r_frame_start;
   assign sync_n      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_controller
// Description : Directed self-checking bench for vga_controller. A second
//               instance with a shortened vertical frame (10 lines) exercises
//               vsync and the full-frame wrap within a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_controller;

`ifdef VGA_SYNC_DELAY_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic       clk;
   logic       reset;
   logic       vga_clk,  hsync,  vsync,  blank_n,  sync_n,  frame_start;
   logic [9:0] x, y;
   logic       vga_clk2, hsync2, vsync2, blank_n2, sync_n2, frame_start2;
   logic [9:0] x2, y2;

   int n_tests = 0;
   int n_fail  = 0;
   int k       = 0;   // rising edges since the last reset release

   vga_controller dut (
      .clk(clk), .reset(reset), .vga_clk(vga_clk), .x(x), .y(y),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
      .frame_start(frame_start)
   );

   // Short vertical frame: visible 0..3, porch 4..5, sync 6..7, back 8..9.
   vga_controller #(.V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) dut2 (
      .clk(clk), .reset(reset), .vga_clk(vga_clk2), .x(x2), .y(y2),
      .hsync(hsync2), .vsync(vsync2), .blank_n(blank_n2), .sync_n(sync_n2),
      .frame_start(frame_start2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the negedge following rising edge number n.
   task automatic run_to(input int n);
      while (k < n) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " vga_clk"}, vga_clk, 0);
      check({tag, " x"}, x, 0);
      check({tag, " y"}, y, 0);
      check({tag, " hsync"}, hsync, 1);
      check({tag, " vsync"}, vsync, 1);
      check({tag, " blank_n"}, blank_n, 0);
      check({tag, " frame_start"}, frame_start, 0);
      check({tag, " sync_n"}, sync_n, 0);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");

      // Release between edges; edge 1 sets pix_en, edge 2 moves x to 1.
      reset = 1'b1;
      k = 0;
      run_to(1);
      check("e1 vga_clk", vga_clk, 1);
      check("e1 x", x, 0);
      check("e1 frame_start", frame_start, 1);
      check("e1 blank_n", blank_n, (D == 0) ? 1 : 0);
      check("e1 hsync", hsync, 1);
      run_to(2);
      check("e2 vga_clk", vga_clk, 0);
      check("e2 x", x, 1);
      check("e2 y", y, 0);
      check("e2 frame_start", frame_start, 0);
      run_to(1 + D);
      check("blank up", blank_n, 1);

      // Pixel clock period of two clk.
      run_to(1001);
      check("vga_clk hi", vga_clk, 1);
      check("x at e1001", x, 500);
      run_to(1002);
      check("vga_clk lo", vga_clk, 0);
      check("x at e1002", x, 501);

      // Horizontal blanking and sync edges (x = edge/2 on line 0).
      run_to(1279 + D);
      check("blank x639", blank_n, 1);
      run_to(1280 + D);
      check("blank x640", blank_n, 0);
      run_to(1311 + D);
      check("hsync x655", hsync, 1);
      run_to(1312 + D);
      check("hsync x656", hsync, 0);
      run_to(1503 + D);
      check("hsync x751", hsync, 0);
      run_to(1504 + D);
      check("hsync x752", hsync, 1);

      // Line wrap: x 799 -> 0 with y 0 -> 1, no frame pulse.
      run_to(1598);
      check("x799", x, 799);
      check("y0", y, 0);
      run_to(1600);
      check("wrap x", x, 0);
      check("wrap y", y, 1);
      check("wrap no frame", frame_start, 0);

      // Visible line 4 on the full frame, blanked on the short frame.
      run_to(6400 + D);
      check("blank y4 full", blank_n, 1);
      check("blank y4 short", blank_n2, 0);

      // Vertical sync on the short frame: lines 6..7.
      run_to(9599 + D);
      check("vsync y5", vsync2, 1);
      run_to(9600 + D);
      check("vsync y6", vsync2, 0);
      check("vsync full y6", vsync, 1);
      run_to(12799 + D);
      check("vsync y7", vsync2, 0);
      run_to(12800 + D);
      check("vsync y8", vsync2, 1);

      // Full-frame wrap on the short frame: 799,9 -> 0,0 on one edge.
      run_to(15998);
      check("pre wrap x", x2, 799);
      check("pre wrap y", y2, 9);
      check("pre wrap frame", frame_start2, 0);
      run_to(15999);
      check("hold x", x2, 799);
      check("hold y", y2, 9);
      run_to(16000);
      check("frame wrap x", x2, 0);
      check("frame wrap y", y2, 0);
      check("frame pulse", frame_start2, 1);
      check("full y10", y, 10);
      check("full no pulse", frame_start, 0);
      run_to(16001);
      check("pulse width", frame_start2, 0);

      // Mid-frame reset between edges at x=300.
      run_to(16600);
      check("mid x300", x, 300);
      check("mid y10", y, 10);
      #2 reset = 1'b0;
      #1;
      check_reset_vals("async");
      repeat (2) @(negedge clk);
      check_reset_vals("held");
      reset = 1'b1;
      k = 0;
      run_to(1);
      check("rel frame_start", frame_start, 1);
      check("rel x", x, 0);
      run_to(2);
      check("rel first x", x, 1);
      check("rel first y", y, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
